// File: rtl/pkt_pkg.sv
// Types shared by the packet-capture scheduler and the pkt_ctrl read/write sequencer.
package pkt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RD_DONE = 2'd2,
    WR_DONE = 2'd3
  } ctrl_state_e;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_RUN  = 3'd2,
    S_WAIT_DONE = 3'd3
  } sched_state_e;

  // Successor of a requester ID in a ring of n requesters.
  function automatic int unsigned wrap_inc(input int unsigned id, input int unsigned n);
    return ((id + 32'd1) >= n) ? 32'd0 : (id + 32'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first pending source at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  winner,
  output logic             any
);

  // Walk offsets from farthest to nearest so the nearest hit is written last and wins.
  always_comb begin
    logic [ID_W:0] sum_s;
    logic [ID_W:0] idx_s;
    winner = '0;
    any    = |pending;
    sum_s  = '0;
    idx_s  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum_s  = {1'b0, rr_ptr} + (ID_W + 1)'(i);
      idx_s  = (sum_s >= (ID_W + 1)'(N_REQ)) ? (sum_s - (ID_W + 1)'(N_REQ)) : sum_s;
      winner = pending[idx_s[ID_W-1:0]] ? idx_s[ID_W-1:0] : winner;
    end
  end

endmodule

// File: rtl/pkt_sched.sv
// Round-robin scheduler feeding packet-capture requests to pkt_ctrl, one transaction at a time,
// with per-transaction completion / timeout reporting.
module pkt_sched
  import pkt_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = 1024,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ctrl_state,
  output logic             new_request,
  output logic [ID_W-1:0]  grant_id,
  output logic             busy,
  output logic [N_REQ-1:0] pending,
  output logic             done,
  output logic [ID_W-1:0]  done_id,
  output logic             timeout_err
);

  localparam int              TMR_W    = $clog2(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = '1;

  sched_state_e     state_r;
  sched_state_e     state_s;
  logic [N_REQ-1:0] pending_r;
  logic [N_REQ-1:0] clear_mask_s;
  logic [ID_W-1:0]  rr_ptr_r;
  logic [ID_W-1:0]  next_ptr_s;
  logic [ID_W-1:0]  grant_id_r;
  logic [ID_W-1:0]  done_id_r;
  logic [TMR_W-1:0] timer_r;
  logic             done_r;
  logic             timeout_err_r;
  logic [ID_W-1:0]  winner_s;
  logic             any_s;
  logic             grant_s;
  logic             timer_clr_s;
  logic             timer_inc_s;
  logic             fin_done_s;
  logic             fin_to_s;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .pending (pending_r),
    .rr_ptr  (rr_ptr_r),
    .winner  (winner_s),
    .any     (any_s)
  );

  assign clear_mask_s = grant_s ? (N_REQ'(1) << winner_s) : '0;
  assign next_ptr_s   = ID_W'(wrap_inc(32'(grant_id_r), N_REQ));

  // Next-state and per-cycle control decode; an exit condition always beats the timeout.
  always_comb begin
    state_s     = state_r;
    grant_s     = 1'b0;
    timer_clr_s = 1'b0;
    timer_inc_s = 1'b0;
    fin_done_s  = 1'b0;
    fin_to_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (any_s) begin
          grant_s = 1'b1;
          state_s = S_ISSUE;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ISSUE: begin
        timer_clr_s = 1'b1;
        state_s     = S_WAIT_RUN;
      end
      S_WAIT_RUN: begin
        if (ctrl_state == RUN) begin
          timer_clr_s = 1'b1;
          state_s     = S_WAIT_DONE;
        end else if (timer_r == TMR_LAST) begin
          fin_to_s = 1'b1;
          state_s  = S_IDLE;
        end else begin
          timer_inc_s = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (ctrl_state == WR_DONE) begin
          fin_done_s = 1'b1;
          state_s    = S_IDLE;
        end else if (timer_r == TMR_LAST) begin
          fin_to_s = 1'b1;
          state_s  = S_IDLE;
        end else begin
          timer_inc_s = 1'b1;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= S_IDLE;
    else        state_r <= state_s;
  end

  // Pending latch: a new request outranks the grant clear in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending_r <= '0;
    else        pending_r <= (pending_r & ~clear_mask_s) | req;
  end

  // Saturating wait-state timer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_r <= '0;
    end else if (timer_clr_s) begin
      timer_r <= '0;
    end else if (timer_inc_s && (timer_r != TMR_MAX)) begin
      timer_r <= timer_r + TMR_W'(1);
    end
  end

  // Grant ID and round-robin pointer; the pointer moves past the source once it finishes either way.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_id_r <= '0;
      rr_ptr_r   <= '0;
    end else begin
      if (grant_s) grant_id_r <= winner_s;
      if (fin_done_s || fin_to_s) rr_ptr_r <= next_ptr_s;
    end
  end

  // Completion reporting pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      done_id_r     <= '0;
    end else begin
      done_r        <= fin_done_s;
      timeout_err_r <= fin_to_s;
      if (fin_done_s || fin_to_s) done_id_r <= grant_id_r;
    end
  end

  assign new_request = (state_r == S_ISSUE);
  assign busy        = (state_r != S_IDLE);
  assign grant_id    = grant_id_r;
  assign pending     = pending_r;
  assign done        = done_r;
  assign done_id     = done_id_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_pkt_sched.sv
// Directed bench for pkt_sched: expected grants and completions are queued when requests are
// driven and popped by a monitor when the scheduler issues or finishes; pkt_ctrl is scripted.
module tb_pkt_sched;
  import pkt_pkg::*;

  localparam int N_REQ   = 4;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [1:0] ctrl_state;
  logic       new_request;
  logic [1:0] grant_id;
  logic       busy;
  logic [3:0] pending;
  logic       done;
  logic [1:0] done_id;
  logic       timeout_err;

  int         checks   = 0;
  int         failures = 0;
  logic [1:0] exp_grant[$];
  logic [2:0] exp_fin[$];   // {is_timeout, id}
  logic [2:0] fin_e;

  pkt_sched #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .ctrl_state  (ctrl_state),
    .new_request (new_request),
    .grant_id    (grant_id),
    .busy        (busy),
    .pending     (pending),
    .done        (done),
    .done_id     (done_id),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_new_request"}, 32'(new_request), 32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_done"},        32'(done),        32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check({tag, "_pending"},     32'(pending),     32'd0);
    check({tag, "_grant_id"},    32'(grant_id),    32'd0);
    check({tag, "_done_id"},     32'(done_id),     32'd0);
  endtask

  // Scoreboard: every issue and every completion must match the next queued expectation.
  always @(negedge clk) begin
    if (new_request === 1'b1) begin
      check("grant_expected", 32'(exp_grant.size() != 0), 32'd1);
      if (exp_grant.size() != 0) check("grant_id", 32'(grant_id), 32'(exp_grant.pop_front()));
    end
    if (done === 1'b1 || timeout_err === 1'b1) begin
      check("fin_expected", 32'(exp_fin.size() != 0), 32'd1);
      if (exp_fin.size() != 0) begin
        fin_e = exp_fin.pop_front();
        check("fin_kind", 32'({timeout_err, done}), fin_e[2] ? 32'd2 : 32'd1);
        check("done_id",  32'(done_id), 32'(fin_e[1:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation still running at 100000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_req(input logic [3:0] r);
    req = r;
    @(negedge clk);
    req = 4'b0000;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Scripted pkt_ctrl for one transaction, counted from the issue cycle (c=0).
  // mode 0: normal, 1: stuck at RD_DONE, 2: WR_DONE on the timeout cycle,
  // 3: never leaves IDLE, other: stop while in S_WAIT_DONE. rereq is pulsed at c=2.
  task automatic serve(input int mode, input logic [3:0] rereq, output int wait_n);
    int end_c;
    wait_n = 0;
    while (new_request !== 1'b1 && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    check("issue_within_bound", 32'(new_request), 32'd1);
    case (mode)
      0:       end_c = 9;
      1:       end_c = 18;
      2:       end_c = 18;
      3:       end_c = 17;
      default: end_c = 4;
    endcase
    for (int c = 1; c <= end_c; c++) begin
      @(negedge clk);
      req = (c == 2) ? rereq : 4'b0000;
      if (c == 3) check("busy_in_flight", 32'(busy), 32'd1);
      case (mode)
        0: ctrl_state = (c <= 3 || (c >= 5 && c <= 7)) ? RUN :
                        (c == 4) ? RD_DONE : (c == 8) ? WR_DONE : IDLE;
        1: ctrl_state = (c == 1) ? RUN : (c < 18) ? RD_DONE : IDLE;
        2: ctrl_state = (c == 1) ? RUN : (c < 17) ? RD_DONE : (c == 17) ? WR_DONE : IDLE;
        3: ctrl_state = IDLE;
        default: ctrl_state = RUN;
      endcase
    end
    if (mode == 0 || mode == 2) begin
      check("done_pulse",     32'(done),        32'd1);
      check("timeout_quiet",  32'(timeout_err), 32'd0);
      check("busy_after_fin", 32'(busy),        32'd0);
    end else if (mode == 1 || mode == 3) begin
      check("timeout_pulse",  32'(timeout_err), 32'd1);
      check("done_quiet",     32'(done),        32'd0);
      check("busy_after_fin", 32'(busy),        32'd0);
    end
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    req        = 4'b0000;
    ctrl_state = IDLE;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("por");
    reset = 1'b1;
    @(negedge clk);

    // Single request: pending in cycle 1, issue in cycle 2 with grant_id 2.
    exp_grant.push_back(2'd2);
    exp_fin.push_back({1'b0, 2'd2});
    pulse_req(4'b0100);
    check("pending_latched", 32'(pending), 32'h4);
    check("no_issue_cycle1", 32'(new_request), 32'd0);
    serve(0, 4'b0000, n);
    check("issue_latency", 32'(n), 32'd1);
    check("pending_clear_single", 32'(pending), 32'd0);

    // Fairness from rr_ptr 0: 0,1,2,3 back-to-back, then 1001 -> 0,3.
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      exp_grant.push_back(2'(i));
      exp_fin.push_back({1'b0, 2'(i)});
    end
    exp_grant.push_back(2'd0); exp_fin.push_back({1'b0, 2'd0});
    exp_grant.push_back(2'd3); exp_fin.push_back({1'b0, 2'd3});
    pulse_req(4'b1111);
    for (int i = 0; i < 4; i++) begin
      serve(0, 4'b0000, n);
      check("back_to_back_gap", 32'(n), 32'd1);
    end
    pulse_req(4'b1001);
    serve(0, 4'b0000, n);
    serve(0, 4'b0000, n);

    // Source 1 re-requests during its own grant and is served again.
    exp_grant.push_back(2'd1); exp_fin.push_back({1'b0, 2'd1});
    exp_grant.push_back(2'd1); exp_fin.push_back({1'b0, 2'd1});
    pulse_req(4'b0010);
    serve(0, 4'b0010, n);
    check("pending_rereq", 32'(pending), 32'h2);
    serve(0, 4'b0000, n);
    check("pending_after_rereq", 32'(pending), 32'd0);

    // Timeout in S_WAIT_DONE (rr_ptr 2 -> grant 0); pointer then sits at 1 so 1001 -> 3,0.
    exp_grant.push_back(2'd0); exp_fin.push_back({1'b1, 2'd0});
    pulse_req(4'b0001);
    serve(1, 4'b0000, n);
    exp_grant.push_back(2'd3); exp_fin.push_back({1'b0, 2'd3});
    exp_grant.push_back(2'd0); exp_fin.push_back({1'b0, 2'd0});
    pulse_req(4'b1001);
    serve(0, 4'b0000, n);
    serve(0, 4'b0000, n);

    // Timeout in S_WAIT_RUN.
    exp_grant.push_back(2'd2); exp_fin.push_back({1'b1, 2'd2});
    pulse_req(4'b0100);
    serve(3, 4'b0000, n);

    // WR_DONE on the timeout cycle completes normally.
    exp_grant.push_back(2'd3); exp_fin.push_back({1'b0, 2'd3});
    pulse_req(4'b1000);
    serve(2, 4'b0000, n);

    // Asynchronous reset mid S_WAIT_DONE with 1010 pending.
    exp_grant.push_back(2'd2);
    pulse_req(4'b0100);
    serve(4, 4'b1010, n);
    check("pre_reset_pending", 32'(pending),  32'hA);
    check("pre_reset_busy",    32'(busy),     32'd1);
    check("pre_reset_grant",   32'(grant_id), 32'd2);
    check("pre_reset_done_id", 32'(done_id),  32'd3);
    #2 reset = 1'b0;
    #1;
    check_idle("async_reset");
    ctrl_state = IDLE;
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check_idle("post_reset");

    check("grant_queue_drained", 32'(exp_grant.size()), 32'd0);
    check("fin_queue_drained",   32'(exp_fin.size()),   32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
